note_seq_player: RTL and testbench

Step sequencer that drives the note-request side of the simple waveform generator. Holds a 2^nbit_bar-step pattern of note addresses, advances one step per programmable tempo period, and presents `per_adx_out`/`per_adx_valid_out` and a metronome `click_en_out` that connect directly to the generator's `per_adx_in`, `per_adx_valid_in` and `click_en_in`. Sits between the control/register block and the waveform generator in the synth top.

---
 rtl/synth_seq_pkg.sv | 30 +++
 rtl/note_seq_player_if.sv | 45 ++++
 rtl/seq_pattern_ram.sv | 31 +++
 rtl/note_seq_player.sv | 133 +++++++++++++
 tb/tb_note_seq_player.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/synth_seq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : synth_seq_pkg
// Description : Shared types and constants for the note step sequencer.
// Revision    : 1.0 - initial release
//==============================================================================
package synth_seq_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PLAY = 1'b1
    } seq_state_t;

    localparam int c_nbit_freq_adx = 7;
    localparam int c_entry_w       = c_nbit_freq_adx + 1;
    localparam int c_rest_bit      = c_nbit_freq_adx;
    localparam int c_min_tempo     = 2;

    // Pattern entry is {rest, note address}; rest sits just above the address.
    function automatic int entry_w(input int nbit_freq_adx);
        return nbit_freq_adx + 1;
    endfunction

    function automatic int rest_bit(input int nbit_freq_adx);
        return nbit_freq_adx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/note_seq_player_if.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : note_seq_player_if
// Description : Control, pattern-write and generator-side signals of the player.
// Revision    : 1.0 - initial release
//==============================================================================
interface note_seq_player_if #(
    parameter int nbit_freq_adx = 7,
    parameter int nbit_bar      = 4,
    parameter int nbit_tempo    = 20
);
    logic                     start;
    logic                     stop;
    logic [nbit_tempo-1:0]    tempo_thr;
    logic [nbit_tempo-1:0]    gate_thr;
    logic [nbit_tempo-1:0]    click_thr;
    logic                     click_on;
    logic                     pat_we;
    logic [nbit_bar-1:0]      pat_wadx;
    logic [nbit_freq_adx:0]   pat_wdata;
    logic [nbit_freq_adx-1:0] per_adx_out;
    logic                     per_adx_valid_out;
    logic                     click_en_out;
    logic [nbit_bar-1:0]      step_idx;
    logic                     bar_start;
    logic                     busy;

    // Register/control side.
    modport master (
        output start, stop, tempo_thr, gate_thr, click_thr, click_on,
               pat_we, pat_wadx, pat_wdata,
        input  per_adx_out, per_adx_valid_out, click_en_out, step_idx,
               bar_start, busy
    );

    // Sequencer side.
    modport slave (
        input  start, stop, tempo_thr, gate_thr, click_thr, click_on,
               pat_we, pat_wadx, pat_wdata,
        output per_adx_out, per_adx_valid_out, click_en_out, step_idx,
               bar_start, busy
    );
endinterface
`default_nettype wire

// File: rtl/seq_pattern_ram.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : seq_pattern_ram
// Description : Pattern store, one write port, one synchronous read-first port.
// Revision    : 1.0 - initial release
//==============================================================================
module seq_pattern_ram #(
    parameter int NBIT_ADX  = 4,
    parameter int NBIT_DATA = 8
) (
    input  wire logic                 clk,
    input  wire logic                 i_we,
    input  wire logic [NBIT_ADX-1:0]  i_wadx,
    input  wire logic [NBIT_DATA-1:0] i_wdata,
    input  wire logic                 i_re,
    input  wire logic [NBIT_ADX-1:0]  i_radx,
    output logic      [NBIT_DATA-1:0] o_rdata
);
    logic [NBIT_DATA-1:0] r_mem [2**NBIT_ADX];

    always_ff @(posedge clk) begin
        if (i_re) begin
            o_rdata <= r_mem[i_radx];
        end
        if (i_we) begin
            r_mem[i_wadx] <= i_wdata;
        end
    end
endmodule
`default_nettype wire

// File: rtl/note_seq_player.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : note_seq_player
// Description : Step sequencer feeding note requests and metronome clicks to
//               the waveform generator.
// Revision    : 1.0 - initial release
//==============================================================================
module note_seq_player
    import synth_seq_pkg::*;
#(
    parameter int nbit_freq_adx = c_nbit_freq_adx,
    parameter int nbit_bar      = 4,
    parameter int nbit_tempo    = 20
) (
    input wire logic          clk,
    input wire logic          rstn,
    note_seq_player_if.slave  bus
);
    localparam int                    c_ent_w     = entry_w(nbit_freq_adx);
    localparam int                    c_rest      = rest_bit(nbit_freq_adx);
    localparam logic [nbit_tempo-1:0] c_tempo_min = nbit_tempo'(c_min_tempo);
    localparam logic [nbit_tempo-1:0] c_tick_one  = nbit_tempo'(1);

    seq_state_t               r_state, w_state_nxt;
    logic [nbit_tempo-1:0]    r_tick_cnt, r_tempo_q;
    logic [nbit_tempo-1:0]    w_tick_nxt, w_tempo_nxt, w_tempo_clamped;
    logic [nbit_bar-1:0]      r_step_idx, w_step_nxt;
    logic [c_ent_w-1:0]       w_ram_rdata;
    logic [nbit_freq_adx-1:0] r_per_adx;
    logic                     r_rest, r_valid, r_click, r_bar_start;
    logic                     w_play_nxt, w_ram_re, w_load_note, w_rest_cur;
    logic                     w_valid_nxt, w_click_nxt, w_bar_nxt;

    assign w_tempo_clamped = (bus.tempo_thr < c_tempo_min) ? c_tempo_min : bus.tempo_thr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start && !bus.stop) w_state_nxt = PLAY;
            PLAY:    if (bus.stop)               w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Counters advance from the state being entered, so every output below can
    // be registered against the tick it will be shown on.
    always_comb begin
        w_tick_nxt  = r_tick_cnt;
        w_step_nxt  = r_step_idx;
        w_tempo_nxt = r_tempo_q;
        if (w_state_nxt == IDLE) begin
            w_tick_nxt = '0;
            w_step_nxt = '0;
        end else if (r_state == IDLE) begin
            w_tick_nxt  = '0;
            w_step_nxt  = '0;
            w_tempo_nxt = w_tempo_clamped;
        end else if (r_tick_cnt == r_tempo_q - 1'b1) begin
            w_tick_nxt  = '0;
            w_step_nxt  = r_step_idx + 1'b1;
            w_tempo_nxt = w_tempo_clamped;
        end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
        end
    end

    always_comb begin
        w_play_nxt  = (w_state_nxt == PLAY);
        w_ram_re    = w_play_nxt && (w_tick_nxt == '0);
        w_load_note = w_play_nxt && (w_tick_nxt == c_tick_one);
        w_rest_cur  = w_load_note ? w_ram_rdata[c_rest] : r_rest;
        // Tick 0 is always silent so the generator re-triggers on every note.
        w_valid_nxt = w_play_nxt && !w_rest_cur && (w_tick_nxt != '0)
                      && (w_tick_nxt <= bus.gate_thr);
        w_click_nxt = w_play_nxt && bus.click_on && (w_step_nxt[1:0] == 2'b00)
                      && (w_tick_nxt != '0) && (w_tick_nxt <= bus.click_thr);
        w_bar_nxt   = w_load_note && (w_step_nxt == '0);
    end

    seq_pattern_ram #(
        .NBIT_ADX  (nbit_bar),
        .NBIT_DATA (c_ent_w)
    ) u_pattern_ram (
        .clk     (clk),
        .i_we    (bus.pat_we),
        .i_wadx  (bus.pat_wadx),
        .i_wdata (bus.pat_wdata),
        .i_re    (w_ram_re),
        .i_radx  (w_step_nxt),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tick_cnt  <= '0;
            r_step_idx  <= '0;
            r_tempo_q   <= '0;
            r_per_adx   <= '0;
            r_rest      <= 1'b0;
            r_valid     <= 1'b0;
            r_click     <= 1'b0;
            r_bar_start <= 1'b0;
        end else begin
            r_tick_cnt  <= w_tick_nxt;
            r_step_idx  <= w_step_nxt;
            r_tempo_q   <= w_tempo_nxt;
            r_valid     <= w_valid_nxt;
            r_click     <= w_click_nxt;
            r_bar_start <= w_bar_nxt;
            if (w_load_note) begin
                r_per_adx <= w_ram_rdata[nbit_freq_adx-1:0];
                r_rest    <= w_ram_rdata[c_rest];
            end
        end
    end

    assign bus.per_adx_out       = r_per_adx;
    assign bus.per_adx_valid_out = r_valid;
    assign bus.click_en_out      = r_click;
    assign bus.step_idx          = r_step_idx;
    assign bus.bar_start         = r_bar_start;
    assign bus.busy              = (r_state == PLAY);
endmodule
`default_nettype wire

// File: tb/tb_note_seq_player.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : tb_note_seq_player
// Description : Scoreboard bench for note_seq_player against a step-level model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_note_seq_player;
    localparam int NFA   = 7;
    localparam int NB    = 4;
    localparam int NT    = 20;
    localparam int STEPS = 16;

    typedef struct packed {
        logic          busy;
        logic [NB-1:0] step;
        logic          valid;
        logic          click;
        logic          bar;
        logic [NFA-1:0] adx;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    note_seq_player_if #(.nbit_freq_adx(NFA), .nbit_bar(NB), .nbit_tempo(NT)) bus ();

    note_seq_player #(.nbit_freq_adx(NFA), .nbit_bar(NB), .nbit_tempo(NT)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model: playing flag, position within the step, the step's length, and
    // the note fetched when the step began.
    bit m_play;
    int m_tick, m_step, m_tempo, m_adx, m_note;
    bit m_rest_cur;
    int m_pat [STEPS];
    bit m_rest[STEPS];

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp_v);
        end
    endtask

    task automatic model_reset();
        m_play = 0; m_tick = 0; m_step = 0; m_tempo = 0;
        m_adx = 0; m_note = 0; m_rest_cur = 0;
    endtask

    task automatic do_cycle();
        exp_t e;
        bit   new_step, con;
        int   g, c;
        @(posedge clk);
        g = int'(bus.gate_thr);
        c = int'(bus.click_thr);
        con = bus.click_on;
        new_step = 0;
        if (!rstn) begin
            model_reset();
        end else begin
            if (!m_play) begin
                if (bus.start && !bus.stop) begin
                    m_play = 1; m_tick = 0; m_step = 0;
                    m_tempo = (int'(bus.tempo_thr) < 2) ? 2 : int'(bus.tempo_thr);
                    new_step = 1;
                end
            end else if (bus.stop) begin
                m_play = 0; m_tick = 0; m_step = 0;
            end else if (m_tick == m_tempo - 1) begin
                m_tick = 0;
                m_step = (m_step + 1) % STEPS;
                m_tempo = (int'(bus.tempo_thr) < 2) ? 2 : int'(bus.tempo_thr);
                new_step = 1;
            end else begin
                m_tick++;
            end
            if (new_step) begin
                m_note = m_pat[m_step];
                m_rest_cur = m_rest[m_step];
            end
            if (m_play && m_tick == 1) m_adx = m_note;
            if (bus.pat_we) begin
                m_pat[int'(bus.pat_wadx)]  = int'(bus.pat_wdata[NFA-1:0]);
                m_rest[int'(bus.pat_wadx)] = bus.pat_wdata[NFA];
            end
        end
        e.busy  = m_play;
        e.step  = m_play ? NB'(m_step) : '0;
        e.valid = m_play && !m_rest_cur && (m_tick >= 1) && (m_tick <= imin(g, m_tempo - 1));
        e.click = m_play && con && (m_step % 4 == 0) && (m_tick >= 1)
                  && (m_tick <= imin(c, m_tempo - 1));
        e.bar   = m_play && (m_step == 0) && (m_tick == 1);
        e.adx   = NFA'(m_adx);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) do_cycle();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1; do_cycle(); bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1; do_cycle(); bus.stop = 1'b0;
    endtask

    task automatic write_pat(input int a, input bit r, input int n);
        bus.pat_we = 1'b1;
        bus.pat_wadx = NB'(a);
        bus.pat_wdata = {r, NFA'(n)};
        do_cycle();
        bus.pat_we = 1'b0;
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("busy",      int'(bus.busy),              int'(e.busy));
                chk("step_idx",  int'(bus.step_idx),          int'(e.step));
                chk("valid",     int'(bus.per_adx_valid_out), int'(e.valid));
                chk("click",     int'(bus.click_en_out),      int'(e.click));
                chk("bar_start", int'(bus.bar_start),         int'(e.bar));
                chk("per_adx",   int'(bus.per_adx_out),       int'(e.adx));
            end
        end
    end

    initial begin
        bus.start = 0; bus.stop = 0; bus.click_on = 0; bus.pat_we = 0;
        bus.tempo_thr = '0; bus.gate_thr = '0; bus.click_thr = '0;
        bus.pat_wadx = '0; bus.pat_wdata = '0;
        for (int i = 0; i < STEPS; i++) begin m_pat[i] = 0; m_rest[i] = 0; end
        model_reset();

        run(3);
        rstn = 1'b1;
        run(1);
        for (int i = 0; i < STEPS; i++) write_pat(i, 1'b0, (10 * (i + 1)) % 128);

        // Basic playback across the bar wrap.
        bus.tempo_thr = NT'(8); bus.gate_thr = NT'(4);
        pulse_start();
        run(STEPS * 8 + 12);
        pulse_stop();
        run(2);

        // Rest on step 3, metronome on, then tempo changes mid-step.
        write_pat(3, 1'b1, 30);
        bus.click_on = 1'b1; bus.click_thr = NT'(2);
        pulse_start();
        run(6 * 8 + 3);
        bus.tempo_thr = NT'(5);
        run(30);
        bus.tempo_thr = NT'(0);
        run(12);

        // Long gate.
        bus.tempo_thr = NT'(6); bus.gate_thr = NT'(100);
        run(40);
        pulse_stop();
        run(2);

        // start and stop together in IDLE.
        bus.start = 1'b1; bus.stop = 1'b1;
        do_cycle();
        bus.start = 1'b0; bus.stop = 1'b0;
        run(3);

        // stop in the middle of a note.
        pulse_start();
        run(9);
        pulse_stop();
        run(3);

        // Asynchronous reset mid-play, then replay with the pattern intact.
        bus.gate_thr = NT'(4);
        pulse_start();
        run(13);
        #1;
        rstn = 1'b0;
        model_reset();
        exp_q[exp_q.size() - 1] = '0;
        run(2);
        rstn = 1'b1;
        run(2);
        pulse_start();
        run(40);

        // Randomised traffic.
        for (int i = 0; i < 800; i++) begin
            bus.start  = ($urandom_range(0, 19) == 0);
            bus.stop   = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 7) == 0) bus.tempo_thr = NT'($urandom_range(0, 7));
            bus.gate_thr  = NT'($urandom_range(0, 8));
            bus.click_thr = NT'($urandom_range(0, 8));
            bus.click_on  = $urandom_range(0, 1) == 1;
            bus.pat_we    = ($urandom_range(0, 3) == 0);
            bus.pat_wadx  = NB'($urandom_range(0, STEPS - 1));
            bus.pat_wdata = (NFA + 1)'($urandom_range(0, 255));
            do_cycle();
        end
        bus.start = 0; bus.stop = 0; bus.pat_we = 0;

        repeat (2) @(posedge clk);
        chk("scoreboard_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
